// File: rtl/enc_8to3_seq.sv
// Sequential 8-to-3 priority encoder: captures a multi-hot vector and emits one set-bit index per transfer.
// Optional macro ENC_ZERO_ERR_EN adds an err pulse on a zero-vector load.
module enc_8to3_seq #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] l,
    input  logic       load,
    output logic [2:0] a,
    output logic       a_valid,
    input  logic       a_ready,
    output logic       last,
`ifdef ENC_ZERO_ERR_EN
    output logic       err,
`endif
    output logic       busy
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t     state;
    logic [7:0] pend;
    logic [7:0] pend_next;
    logic       xfer;

    function automatic logic [2:0] pick_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    assign xfer      = a_valid && a_ready;
    assign pend_next = pend & ~(8'd1 << a);

    // a and last are precomputed for the value pend will hold, so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend    <= 8'd0;
            a       <= 3'd0;
            a_valid <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
`ifdef ENC_ZERO_ERR_EN
            err     <= 1'b0;
`endif
        end else begin
`ifdef ENC_ZERO_ERR_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (load && (l != 8'd0)) begin
                        state   <= EMIT;
                        pend    <= l;
                        a       <= pick_index(l);
                        last    <= single_bit(l);
                        a_valid <= 1'b1;
                        busy    <= 1'b1;
                    end
`ifdef ENC_ZERO_ERR_EN
                    else if (load) begin
                        err <= 1'b1;
                    end
`endif
                end
                EMIT: begin
                    if (xfer) begin
                        pend <= pend_next;
                        if (last) begin
                            state   <= IDLE;
                            a       <= 3'd0;
                            a_valid <= 1'b0;
                            last    <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            a    <= pick_index(pend_next);
                            last <= single_bit(pend_next);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
